// File: rtl/osf_pipe_arbiter.sv
// Round-robin arbiter that merges N_ADC oversample-filter channels into one pipe FIFO as two-word tagged frames.
// Latency: grant 1 cycle after capture, registered header/data words 1 cycle after HDR/DATA; frames stall in place while fifo_ready_in=0.
module osf_pipe_arbiter #(
  parameter int N_ADC      = 8,
  parameter int W_ADC_DATA = 18,
  parameter int W_EP       = 16,
  parameter int W_DROP     = 16
) (
  input  logic                        clk50_in,
  input  logic                        rst_n_in,
  input  logic                        flush_in,
  input  logic [N_ADC-1:0]            chan_en_in,
  input  logic [N_ADC-1:0]            data_valid_in,
  input  logic [N_ADC*W_ADC_DATA-1:0] data_packed_in,
  input  logic                        fifo_ready_in,
  output logic                        out_valid_out,
  output logic [W_EP-1:0]             out_data_out,
  output logic [W_DROP-1:0]           drop_count_out,
  output logic                        busy_out
);

  localparam int IDX_W = (N_ADC > 1) ? $clog2(N_ADC) : 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_ADC - 1);

  logic [W_ADC_DATA-1:0] sample [N_ADC];

  logic [1:0]            state_q, state_d;
  logic [N_ADC-1:0]      pend_q, pend_d;
  logic [W_ADC_DATA-1:0] hold_q [N_ADC];
  logic [W_ADC_DATA-1:0] hold_d [N_ADC];
  logic [IDX_W-1:0]      last_q, last_d;
  logic [3:0]            gnt_q, gnt_d;
  logic [W_EP-1:0]       frame_q, frame_d;
  logic [7:0]            seq_q, seq_d;
  logic [W_DROP-1:0]     drop_q, drop_d;
  logic                  out_valid_q, out_valid_d;
  logic [W_EP-1:0]       out_data_q, out_data_d;

  logic                  rr_found;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_go;
  logic [N_ADC-1:0]      gnt_oh;
  logic [4:0]            drops;
  logic [W_DROP:0]       drop_sum;
  logic [15:0]           hdr_word;
  int                    cand;

  genvar gi;
  generate
    for (gi = 0; gi < N_ADC; gi++) begin : g_unpack
      assign sample[gi] = data_packed_in[gi*W_ADC_DATA +: W_ADC_DATA];
    end
  endgenerate

  // Search starts one past the last granted channel and wraps at N_ADC.
  always_comb begin
    rr_found = 1'b0;
    gnt_idx  = last_q;
    cand     = 0;
    for (int k = 1; k <= N_ADC; k++) begin
      cand = int'(last_q) + k;
      if (cand >= N_ADC) cand = cand - N_ADC;
      if (!rr_found && pend_q[IDX_W'(cand)]) begin
        rr_found = 1'b1;
        gnt_idx  = IDX_W'(cand);
      end
    end
  end

  assign gnt_go   = (state_q == ST_IDLE) && fifo_ready_in && rr_found;
  assign hdr_word = {4'hA, gnt_q, seq_q};

  always_comb begin
    gnt_oh = '0;
    if (gnt_go) gnt_oh[gnt_idx] = 1'b1;
  end

  // A capture in the grant cycle re-arms the channel with fresh data rather than counting as an overrun.
  always_comb begin
    pend_d = pend_q;
    hold_d = hold_q;
    drops  = 5'd0;
    for (int a = 0; a < N_ADC; a++) begin
      if (gnt_oh[a]) pend_d[a] = 1'b0;
      if (!chan_en_in[a]) begin
        pend_d[a] = 1'b0;
      end else if (data_valid_in[a]) begin
        hold_d[a] = sample[a];
        pend_d[a] = 1'b1;
        if (pend_q[a] && !gnt_oh[a]) drops = drops + 5'd1;
      end
    end
    drop_sum = {1'b0, drop_q} + (W_DROP+1)'(drops);
    drop_d   = drop_sum[W_DROP] ? {W_DROP{1'b1}} : drop_sum[W_DROP-1:0];
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    frame_d     = frame_q;
    seq_d       = seq_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_go) begin
          frame_d = hold_q[gnt_idx][W_ADC_DATA-1 -: W_EP];
          gnt_d   = 4'(gnt_idx);
          last_d  = gnt_idx;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (fifo_ready_in) begin
          out_valid_d = 1'b1;
          out_data_d  = W_EP'(hdr_word);
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fifo_ready_in) begin
          out_valid_d = 1'b1;
          out_data_d  = frame_q;
          seq_d       = seq_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      for (int a = 0; a < N_ADC; a++) hold_q[a] <= '0;
      last_q      <= LAST_RST;
      gnt_q       <= '0;
      frame_q     <= '0;
      seq_q       <= '0;
      drop_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (flush_in) begin
      // Flush discards any in-flight frame; nothing more is written for it.
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      for (int a = 0; a < N_ADC; a++) hold_q[a] <= '0;
      last_q      <= LAST_RST;
      gnt_q       <= '0;
      frame_q     <= '0;
      seq_q       <= '0;
      drop_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      frame_q     <= frame_d;
      seq_q       <= seq_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid_out  = out_valid_q;
  assign out_data_out   = out_data_q;
  assign drop_count_out = drop_q;
  assign busy_out       = (state_q != ST_IDLE);

endmodule
